spi_xfer_sched: RTL

- Wishbone master that shares the SPI core (spi_top) between two transfer requesters.
- Grants one requester at a time, round-robin, and runs the full register sequence for each transfer: CTRL config, DIVIDER, SS, TX0, CTRL go, poll go_busy, read RX0.
- Returns the received word and an error flag to the granted requester.
- Sits between the client logic and the spi_top Wishbone slave port, in place of the bench Wishbone master.

---
 rtl/spi_xfer_sched.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched: Wishbone master that time-shares one spi_top core between
// two transfer requesters. Each granted request is turned into the full
// CTRL/DIVIDER/SS/TX0/GO/poll/RX0 register sequence, and the result is
// returned to the requester that was granted.
module spi_xfer_sched #(
    parameter int POLL_MAX = 1023
) (
    input  logic        wb_clk_in,
    input  logic        wb_rst_in,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_data,
    input  logic [15:0] req_ss,
    input  logic [19:0] req_cfg,
    input  logic [15:0] div_in,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [4:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy
);

    localparam logic [4:0] ADR_RX0  = 5'h00;
    localparam logic [4:0] ADR_CTRL = 5'h10;
    localparam logic [4:0] ADR_DIV  = 5'h14;
    localparam logic [4:0] ADR_SS   = 5'h18;

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_DIV, S_SS, S_TX, S_GO, S_POLL, S_RX, S_GAP, S_DONE
    } state_t;

    state_t state, state_nxt;
    state_t ret_q, ret_nxt;

    // Transfer context captured at the grant
    logic        last_q;
    logic [31:0] data_q;
    logic [7:0]  ss_q;
    logic [9:0]  cfg_q;
    logic [15:0] div_q;
    logic [9:0]  poll_cnt;

    logic        grant_en;
    logic        grant_id;
    logic [9:0]  cfg_src;
    logic [9:0]  poll_inc;
    logic        poll_timeout;
    logic        in_access;

    logic        nxt_cyc;
    logic        nxt_we;
    logic [4:0]  nxt_adr;
    logic [31:0] nxt_dat;

    // CTRL layout: len[6:0], go[8], rx_neg[9], tx_neg[10], lsb[11], ie[12]=0, ass[13]=1
    function automatic logic [31:0] ctrl_word(input logic [9:0] cfg, input logic go);
        return {18'b0, 1'b1, 1'b0, cfg[9:7], go, 1'b0, cfg[6:0]};
    endfunction

    function automatic logic is_access(input state_t s);
        return (s == S_CFG) || (s == S_DIV) || (s == S_SS) || (s == S_TX) ||
               (s == S_GO) || (s == S_POLL) || (s == S_RX);
    endfunction

    // Round-robin arbitration, only meaningful while idle
    always_comb begin
        grant_id     = (&req_valid) ? ~last_q : req_valid[1];
        grant_en     = (state == S_IDLE) && (|req_valid);
        cfg_src      = (state == S_IDLE) ? (grant_id ? req_cfg[19:10] : req_cfg[9:0]) : cfg_q;
        poll_inc     = poll_cnt + 10'd1;
        poll_timeout = (poll_inc >= 10'(POLL_MAX));
        in_access    = is_access(state);
    end

    // State register, including the access to resume after a GAP cycle
    always_ff @(posedge wb_clk_in or negedge wb_rst_in) begin
        if (!wb_rst_in) begin
            state <= S_IDLE;
            ret_q <= S_IDLE;
        end else begin
            state <= state_nxt;
            ret_q <= ret_nxt;
        end
    end

    // Next-state logic: one Wishbone access per state, err beats ack
    always_comb begin
        state_nxt = state;
        ret_nxt   = ret_q;
        case (state)
            S_IDLE: if (grant_en) state_nxt = S_CFG;
            S_CFG, S_DIV, S_SS, S_TX, S_GO, S_RX: begin
                if (wb_err_i) begin
                    state_nxt = S_DONE;
                end else if (wb_ack_i) begin
                    state_nxt = (state == S_RX) ? S_DONE : S_GAP;
                    case (state)
                        S_CFG:   ret_nxt = S_DIV;
                        S_DIV:   ret_nxt = S_SS;
                        S_SS:    ret_nxt = S_TX;
                        S_TX:    ret_nxt = S_GO;
                        default: ret_nxt = S_POLL;
                    endcase
                end
            end
            S_POLL: begin
                if (wb_err_i) begin
                    state_nxt = S_DONE;
                end else if (wb_ack_i) begin
                    if (wb_dat_i[8] && poll_timeout) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_GAP;
                        ret_nxt   = wb_dat_i[8] ? S_POLL : S_RX;
                    end
                end
            end
            S_GAP:   state_nxt = ret_q;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next bus cycle contents plus the combinational handshakes
    always_comb begin
        nxt_cyc = 1'b0;
        nxt_we  = 1'b0;
        nxt_adr = 5'h00;
        nxt_dat = 32'h0;
        case (state_nxt)
            S_CFG:  begin nxt_cyc = 1'b1; nxt_we = 1'b1; nxt_adr = ADR_CTRL; nxt_dat = ctrl_word(cfg_src, 1'b0); end
            S_DIV:  begin nxt_cyc = 1'b1; nxt_we = 1'b1; nxt_adr = ADR_DIV;  nxt_dat = {16'b0, div_q}; end
            S_SS:   begin nxt_cyc = 1'b1; nxt_we = 1'b1; nxt_adr = ADR_SS;   nxt_dat = {24'b0, ss_q}; end
            S_TX:   begin nxt_cyc = 1'b1; nxt_we = 1'b1; nxt_adr = ADR_RX0;  nxt_dat = data_q; end
            S_GO:   begin nxt_cyc = 1'b1; nxt_we = 1'b1; nxt_adr = ADR_CTRL; nxt_dat = ctrl_word(cfg_q, 1'b1); end
            S_POLL: begin nxt_cyc = 1'b1; nxt_adr = ADR_CTRL; end
            S_RX:   begin nxt_cyc = 1'b1; nxt_adr = ADR_RX0; end
            default: ;
        endcase
        // Gated by reset so no acceptance is signalled while the block is held
        req_ready = (grant_en && wb_rst_in) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
        rsp_valid = (state == S_DONE);
        busy      = (state != S_IDLE);
    end

    // Registered Wishbone outputs; values only change when the state does
    always_ff @(posedge wb_clk_in or negedge wb_rst_in) begin
        if (!wb_rst_in) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= 5'h00;
            wb_dat_o <= 32'h0;
            wb_sel_o <= 4'h0;
        end else begin
            wb_cyc_o <= nxt_cyc;
            wb_stb_o <= nxt_cyc;
            wb_we_o  <= nxt_we;
            wb_adr_o <= nxt_adr;
            wb_dat_o <= nxt_dat;
            wb_sel_o <= nxt_cyc ? 4'hF : 4'h0;
        end
    end

    // Request capture at the grant; held for the whole transfer
    always_ff @(posedge wb_clk_in) begin
        if (grant_en) begin
            data_q <= grant_id ? req_data[63:32] : req_data[31:0];
            ss_q   <= grant_id ? req_ss[15:8]    : req_ss[7:0];
            cfg_q  <= cfg_src;
            div_q  <= div_in;
        end
    end

    // Arbitration history, poll counter and response fields
    always_ff @(posedge wb_clk_in or negedge wb_rst_in) begin
        if (!wb_rst_in) begin
            last_q   <= 1'b1;
            poll_cnt <= 10'd0;
            rsp_id   <= 1'b0;
            rsp_data <= 32'h0;
            rsp_err  <= 1'b0;
        end else begin
            if (grant_en) begin
                last_q   <= grant_id;
                rsp_id   <= grant_id;
                rsp_data <= 32'h0;
                rsp_err  <= 1'b0;
            end
            if (state == S_GO) begin
                poll_cnt <= 10'd0;
            end else if (state == S_POLL && wb_ack_i && !wb_err_i) begin
                poll_cnt <= poll_inc;
            end
            if (in_access && wb_err_i) begin
                rsp_err  <= 1'b1;
                rsp_data <= 32'h0;
            end else if (state == S_POLL && wb_ack_i && wb_dat_i[8] && poll_timeout) begin
                rsp_err  <= 1'b1;
                rsp_data <= 32'h0;
            end else if (state == S_RX && wb_ack_i) begin
                rsp_data <= wb_dat_i;
            end
        end
    end

endmodule
